// File: rtl/pc_unit.sv
// Program-counter unit: registered PC with increment/branch/jump/call/return
// and a return-address stack that reports full/empty and sticky misuse flags.
module pc_unit #(
    parameter int                ADDR_W      = 5,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
    parameter int                STACK_DEPTH = 4,
    localparam int               CNT_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] target,
    input  logic [ADDR_W-1:0] offset,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  stack_cnt,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              ovf_err,
    output logic              unf_err
);

    localparam logic [2:0] OP_INC  = 3'd0;
    localparam logic [2:0] OP_BR   = 3'd1;
    localparam logic [2:0] OP_JMP  = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_stack_cnt;
    logic              r_ovf_err;
    logic              r_unf_err;
    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_top;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_push;
    logic              w_ovf_set;
    logic              w_unf_set;
    logic              w_full;
    logic              w_empty;

    assign w_pc_inc = r_pc + ADDR_W'(1);
    assign w_full   = (r_stack_cnt == CNT_FULL);
    assign w_empty  = (r_stack_cnt == CNT_W'(0));

    // Select the top-of-stack entry (slot stack_cnt-1); don't-care when empty.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            w_top = (r_stack_cnt == CNT_W'(i + 1)) ? r_stack[i] : w_top;
        end
    end

    // Next-address and stack-control decode; stall overrides every op.
    always_comb begin
        w_pc_nxt  = w_pc_inc;
        w_cnt_nxt = r_stack_cnt;
        w_push    = 1'b0;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        if (stall) begin
            w_pc_nxt = r_pc;
        end else begin
            case (op)
                OP_INC:  w_pc_nxt = w_pc_inc;
                OP_BR:   w_pc_nxt = r_pc + offset;
                OP_JMP:  w_pc_nxt = target;
                OP_CALL: begin
                    w_pc_nxt = target;
                    if (!w_full) begin
                        w_push    = 1'b1;
                        w_cnt_nxt = r_stack_cnt + CNT_W'(1);
                    end else begin
                        w_ovf_set = 1'b1;
                    end
                end
                OP_RET: begin
                    if (!w_empty) begin
                        w_pc_nxt  = w_top;
                        w_cnt_nxt = r_stack_cnt - CNT_W'(1);
                    end else begin
                        w_pc_nxt  = w_pc_inc;
                        w_unf_set = 1'b1;
                    end
                end
                default: w_pc_nxt = w_pc_inc;
            endcase
        end
    end

    // Architectural state: PC, stack depth and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_VEC;
            r_stack_cnt <= '0;
            r_ovf_err   <= 1'b0;
            r_unf_err   <= 1'b0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_stack_cnt <= w_cnt_nxt;
            r_ovf_err   <= r_ovf_err | w_ovf_set;
            r_unf_err   <= r_unf_err | w_unf_set;
        end
    end

    // Return-address storage; contents are don't-care after reset so no reset term.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (w_push && (r_stack_cnt == CNT_W'(i))) begin
                r_stack[i] <= w_pc_inc;
            end
        end
    end

    assign pc          = r_pc;
    assign stack_cnt   = r_stack_cnt;
    assign stack_empty = w_empty;
    assign stack_full  = w_full;
    assign ovf_err     = r_ovf_err;
    assign unf_err     = r_unf_err;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: expected state is queued as each op is driven
// and compared against the DUT one clock later.
module tb_pc_unit;

    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    localparam logic [2:0] OP_INC  = 3'd0;
    localparam logic [2:0] OP_BR   = 3'd1;
    localparam logic [2:0] OP_JMP  = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;

    typedef struct packed {
        logic [4:0] pc;
        logic [2:0] cnt;
        logic       empty;
        logic       full;
        logic       ovf;
        logic       unf;
    } st_t;

    typedef struct packed {
        logic [2:0] op;
        logic [4:0] tgt;
        logic [4:0] off;
        logic       stl;
        logic [4:0] pc;
        logic [2:0] cnt;
        logic       ovf;
        logic       unf;
    } step_t;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          stall  = 1'b0;
    logic [2:0]    op     = 3'd0;
    logic [AW-1:0] target = '0;
    logic [AW-1:0] offset = '0;
    logic [AW-1:0] pc;
    logic [CW-1:0] stack_cnt;
    logic          stack_empty;
    logic          stack_full;
    logic          ovf_err;
    logic          unf_err;

    int checks   = 0;
    int failures = 0;
    st_t sb [$];

    pc_unit #(.ADDR_W(AW), .RESET_VEC(5'd0), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .op(op),
        .target(target), .offset(offset), .pc(pc), .stack_cnt(stack_cnt),
        .stack_empty(stack_empty), .stack_full(stack_full),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    function automatic st_t mk(logic [4:0] p, logic [2:0] c, logic o, logic u);
        return '{pc: p, cnt: c, empty: (c == 3'd0), full: (c == 3'd4), ovf: o, unf: u};
    endfunction

    function automatic st_t observe();
        return {pc, stack_cnt, stack_empty, stack_full, ovf_err, unf_err};
    endfunction

    task automatic drive(input step_t s);
        op     = s.op;
        target = s.tgt;
        offset = s.off;
        stall  = s.stl;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        st_t e, o;
        rst_n = 1'b0;
        op    = OP_INC;
        for (int k = 0; k < 2; k++) begin
            sb.push_back(mk(5'd0, 3'd0, 1'b0, 1'b0));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset cyc=%0d got=%b exp=%b", k, o, e);
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 33; k++) begin
            sb.push_back(mk(5'(k + 1), 3'd0, 1'b0, 1'b0));
            drive('{OP_INC, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0});
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL inc step=%0d got pc=%0d cnt=%0d fl=%b exp pc=%0d cnt=%0d fl=%b",
                         k, o.pc, o.cnt, o[3:0], e.pc, e.cnt, e[3:0]);
            end
        end
    endtask

    task automatic test_async_reset();
        st_t e, o;
        step_t tbl [3];
        tbl = '{'{OP_JMP,  5'd5,  5'd0, 1'b0, 5'd5,  3'd0, 1'b0, 1'b0},
                '{OP_CALL, 5'd10, 5'd0, 1'b0, 5'd10, 3'd1, 1'b0, 1'b0},
                '{OP_CALL, 5'd13, 5'd0, 1'b0, 5'd13, 3'd2, 1'b0, 1'b0}};
        foreach (tbl[k]) begin
            sb.push_back(mk(tbl[k].pc, tbl[k].cnt, tbl[k].ovf, tbl[k].unf));
            drive(tbl[k]);
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL async_setup step=%0d got=%b exp=%b", k, o, e);
            end
        end
        op = OP_INC;
        #2;
        sb.push_back(mk(5'd0, 3'd0, 1'b0, 1'b0));
        rst_n = 1'b0;
        #1;
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL async_reset got pc=%0d cnt=%0d exp pc=%0d cnt=%0d", o.pc, o.cnt, e.pc, e.cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_branch_jump();
        st_t e, o;
        step_t tbl [5];
        tbl = '{'{OP_JMP, 5'd10, 5'd0,      1'b0, 5'd10, 3'd0, 1'b0, 1'b0},
                '{OP_BR,  5'd0,  5'b11101,  1'b0, 5'd7,  3'd0, 1'b0, 1'b0},
                '{OP_BR,  5'd0,  5'd25,     1'b0, 5'd0,  3'd0, 1'b0, 1'b0},
                '{OP_JMP, 5'd20, 5'd0,      1'b0, 5'd20, 3'd0, 1'b0, 1'b0},
                '{OP_BR,  5'd3,  5'd0,      1'b0, 5'd20, 3'd0, 1'b0, 1'b0}};
        foreach (tbl[k]) begin
            sb.push_back(mk(tbl[k].pc, tbl[k].cnt, tbl[k].ovf, tbl[k].unf));
            drive(tbl[k]);
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL branch_jump step=%0d got pc=%0d exp pc=%0d got=%b exp=%b", k, o.pc, e.pc, o, e);
            end
        end
    endtask

    task automatic test_nested_call();
        st_t e, o;
        step_t tbl [8];
        tbl = '{'{OP_JMP,  5'd3,  5'd0, 1'b0, 5'd3,  3'd0, 1'b0, 1'b0},
                '{OP_CALL, 5'd16, 5'd0, 1'b0, 5'd16, 3'd1, 1'b0, 1'b0},
                '{OP_CALL, 5'd24, 5'd0, 1'b0, 5'd24, 3'd2, 1'b0, 1'b0},
                '{OP_RET,  5'd9,  5'd0, 1'b0, 5'd17, 3'd1, 1'b0, 1'b0},
                '{OP_RET,  5'd9,  5'd0, 1'b0, 5'd4,  3'd0, 1'b0, 1'b0},
                '{OP_JMP,  5'd31, 5'd0, 1'b0, 5'd31, 3'd0, 1'b0, 1'b0},
                '{OP_CALL, 5'd8,  5'd0, 1'b0, 5'd8,  3'd1, 1'b0, 1'b0},
                '{OP_RET,  5'd0,  5'd0, 1'b0, 5'd0,  3'd0, 1'b0, 1'b0}};
        foreach (tbl[k]) begin
            sb.push_back(mk(tbl[k].pc, tbl[k].cnt, tbl[k].ovf, tbl[k].unf));
            drive(tbl[k]);
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL nested_call step=%0d got pc=%0d cnt=%0d fl=%b exp pc=%0d cnt=%0d fl=%b",
                         k, o.pc, o.cnt, o[3:0], e.pc, e.cnt, e[3:0]);
            end
        end
    endtask

    task automatic test_ovf_unf();
        st_t e, o;
        step_t tbl [11];
        tbl = '{'{OP_JMP,  5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0},
                '{OP_CALL, 5'd8, 5'd0, 1'b0, 5'd8, 3'd1, 1'b0, 1'b0},
                '{OP_CALL, 5'd8, 5'd0, 1'b0, 5'd8, 3'd2, 1'b0, 1'b0},
                '{OP_CALL, 5'd8, 5'd0, 1'b0, 5'd8, 3'd3, 1'b0, 1'b0},
                '{OP_CALL, 5'd8, 5'd0, 1'b0, 5'd8, 3'd4, 1'b0, 1'b0},
                '{OP_CALL, 5'd8, 5'd0, 1'b0, 5'd8, 3'd4, 1'b1, 1'b0},
                '{OP_RET,  5'd0, 5'd0, 1'b0, 5'd9, 3'd3, 1'b1, 1'b0},
                '{OP_RET,  5'd0, 5'd0, 1'b0, 5'd9, 3'd2, 1'b1, 1'b0},
                '{OP_RET,  5'd0, 5'd0, 1'b0, 5'd9, 3'd1, 1'b1, 1'b0},
                '{OP_RET,  5'd0, 5'd0, 1'b0, 5'd1, 3'd0, 1'b1, 1'b0},
                '{OP_RET,  5'd0, 5'd0, 1'b0, 5'd2, 3'd0, 1'b1, 1'b1}};
        foreach (tbl[k]) begin
            sb.push_back(mk(tbl[k].pc, tbl[k].cnt, tbl[k].ovf, tbl[k].unf));
            drive(tbl[k]);
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL ovf_unf step=%0d got pc=%0d cnt=%0d fl=%b exp pc=%0d cnt=%0d fl=%b",
                         k, o.pc, o.cnt, o[3:0], e.pc, e.cnt, e[3:0]);
            end
        end
    endtask

    task automatic test_stall();
        st_t e, o;
        step_t tbl [10];
        op = OP_INC;
        rst_n = 1'b0;
        sb.push_back(mk(5'd0, 3'd0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL flags_clear got=%b exp=%b", o, e);
        end
        rst_n = 1'b1;
        tbl = '{'{OP_JMP,  5'd2,  5'd0, 1'b0, 5'd2, 3'd0, 1'b0, 1'b0},
                '{OP_CALL, 5'd5,  5'd0, 1'b0, 5'd5, 3'd1, 1'b0, 1'b0},
                '{OP_RET,  5'd0,  5'd0, 1'b1, 5'd5, 3'd1, 1'b0, 1'b0},
                '{OP_RET,  5'd0,  5'd0, 1'b1, 5'd5, 3'd1, 1'b0, 1'b0},
                '{OP_RET,  5'd0,  5'd0, 1'b1, 5'd5, 3'd1, 1'b0, 1'b0},
                '{OP_INC,  5'd0,  5'd0, 1'b0, 5'd6, 3'd1, 1'b0, 1'b0},
                '{OP_RET,  5'd0,  5'd0, 1'b0, 5'd3, 3'd0, 1'b0, 1'b0},
                '{OP_RET,  5'd0,  5'd0, 1'b1, 5'd3, 3'd0, 1'b0, 1'b0},
                '{OP_CALL, 5'd20, 5'd0, 1'b1, 5'd3, 3'd0, 1'b0, 1'b0},
                '{OP_RET,  5'd0,  5'd0, 1'b0, 5'd4, 3'd0, 1'b0, 1'b1}};
        foreach (tbl[k]) begin
            sb.push_back(mk(tbl[k].pc, tbl[k].cnt, tbl[k].ovf, tbl[k].unf));
            drive(tbl[k]);
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL stall step=%0d got pc=%0d cnt=%0d fl=%b exp pc=%0d cnt=%0d fl=%b",
                         k, o.pc, o.cnt, o[3:0], e.pc, e.cnt, e[3:0]);
            end
        end
        stall = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_async_reset();
        test_branch_jump();
        test_nested_call();
        test_ovf_unf();
        test_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit; successor to the fixed 5-bit PC register.
- Holds the current instruction address and computes the next one from a per-cycle operation: increment, relative branch, absolute jump, call or return.
- Includes a hardware return-address stack with full/empty status and sticky error flags.
- Sits between the decode/control unit (drives op, target, offset, stall) and instruction memory (consumes pc).

Parameters:
- ADDR_W, 5, address width in bits (min 2).
- RESET_VEC, 0, value loaded into pc on reset (ADDR_W bits).
- STACK_DEPTH, 4, return-address stack entries (min 1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  1 = hold all state this cycle; op ignored.
- op  input  3  next-address operation: 0 INC, 1 BR, 2 JMP, 3 CALL, 4 RET, 5-7 reserved (behave as INC).
- target  input  ADDR_W  absolute destination for JMP/CALL.
- offset  input  ADDR_W  two's-complement displacement for BR.
- pc  output  ADDR_W  current instruction address, registered.
- stack_cnt  output  clog2(STACK_DEPTH+1)  entries currently on stack.
- stack_empty  output  1  stack_cnt == 0.
- stack_full  output  1  stack_cnt == STACK_DEPTH.
- ovf_err  output  1  sticky: CALL attempted while full.
- unf_err  output  1  sticky: RET attempted while empty.

Behaviour:
- Reset, asserted asynchronously on rst_n low:
  - pc = RESET_VEC; stack_cnt = 0; ovf_err = 0; unf_err = 0.
  - stack_empty = 1; stack_full = 0.
  - Stack storage is not cleared and its contents are don't-care.
- Reset release is synchronous to clk. The first update occurs on the first rising edge with rst_n high.
- Reset mid-operation discards any in-flight call chain.
- Latency: pc updates on the rising edge after op is presented. pc is combinationally independent of the inputs.
- stall = 1: pc, stack contents, stack_cnt and error flags are all held. stall has priority over every op.
- All additions wrap modulo 2^ADDR_W, with no carry out. pc_inc = pc + 1.
- INC (and reserved ops): pc <= pc_inc. pc = all-ones wraps to 0.
- BR: pc <= pc + offset, with offset sign-interpreted. offset = 0 holds pc (self-loop).
- JMP: pc <= target.
- CALL, not full: stack[stack_cnt] <= pc_inc; stack_cnt++; pc <= target.
- CALL, full: pc <= target; no push; stack_cnt unchanged; ovf_err <= 1.
- RET, not empty: pc <= stack[stack_cnt-1]; stack_cnt--.
- RET, empty: pc <= pc_inc; stack_cnt unchanged; unf_err <= 1.
- Stack is LIFO. A CALL followed by RET with no intervening stack ops returns to the CALL address + 1, including the wrap case (CALL at all-ones pushes 0).
- Error flags clear only on reset.
- stack_empty, stack_full and stack_cnt are registered state or decoded directly from stack_cnt, consistent on every cycle.

Test Plan (ADDR_W=5, RESET_VEC=0, STACK_DEPTH=4 unless stated):
- Reset/increment:
  - Stimulus: hold rst_n=0 for 2 cycles, release; op=INC for 33 cycles.
  - Required: pc=0 during reset; then 1,2,...,31,0,1 (wrap at 31->0); stack_empty=1 throughout.
- Async reset:
  - Stimulus: drop rst_n mid-cycle while pc=13 and stack_cnt=2.
  - Required: pc=0 and stack_cnt=0 immediately, without waiting for a clk edge.
- Branch/jump:
  - Stimulus: from pc=10, BR offset=5'b11101 (-3); then BR offset=25; then JMP target=20.
  - Required: pc=7, then 0 (32 mod 32), then 20.
- Nested call/return:
  - Stimulus: pc=3 CALL 16; at 16 CALL 24; at 24 RET; then RET.
  - Required: pc=16, 24, 17, 4; stack_cnt=1, 2, 1, 0; no error flags.
- Overflow/underflow:
  - Overflow stimulus: 5 consecutive CALLs to target=8 starting from pc=0.
  - Overflow required: stack_full=1 after the 4th; 5th sets ovf_err=1 with pc=8 and stack_cnt=4. Four RETs then return 9,9,9,1.
  - Underflow stimulus: one further RET at pc=1.
  - Underflow required: pc=2 and unf_err=1.
- Stall priority:
  - Stimulus: with stack_cnt=1 and pc=5, stall=1 for 3 cycles with op=RET, then stall=0 with op=INC.
  - Required: pc stays 5 and stack_cnt stays 1 during stall; then pc=6.
